iencoder: RTL and testbench
===========================

Name: iencoder

Overview:
- Instruction encoder: packs RV32I fields (opcode, rd, rs1, rs2, funct3, funct7, imm) into a 32-bit instruction word.
- Inverse of the instruction decoder. Serves as the self-checking stimulus source for decoder and core benches (encode→decode round trip) and as the backend of the on-chip test-program builder.
- Valid/ready request side, valid/ready response side, simulated multi-cycle latency matching the decoder's delay model.

Parameters:
- LATENCY, 4, cycles from request acceptance to resp_valid; legal range 1..15.
- DATA_WIDTH, 32, instruction and immediate width.
- REG_ADDR_WIDTH, 5, register address width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request fields valid.
- req_ready  output  1  encoder can accept a request.
- opcode  input  7  opcode_t from _riscv_defines.
- rd_addr  input  REG_ADDR_WIDTH  destination register.
- rs1_addr  input  REG_ADDR_WIDTH  source register 1.
- rs2_addr  input  REG_ADDR_WIDTH  source register 2.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field.
- imm  input  DATA_WIDTH  full sign-extended byte-offset immediate (decoder convention).
- resp_valid  output  1  instruction/resp_err valid.
- resp_ready  input  1  consumer accepts response.
- instruction  output  DATA_WIDTH  encoded word.
- resp_err  output  1  encoding error.

Behaviour:
- Reset: async on rst high. state=IDLE, req_ready=0 while rst=1 (becomes 1 in IDLE after release), resp_valid=0, instruction=0, resp_err=0, counter=0. Reset mid-operation discards the in-flight request; no response is produced.
- States:
  - IDLE: req_ready=1. On req_valid, latch all fields, counter=LATENCY-1, go to BUSY.
  - BUSY: req_ready=0. Counter decrements each cycle. When counter==0, register the packed instruction and resp_err, set resp_valid=1, go to RESP.
  - RESP: hold resp_valid, instruction and resp_err stable until resp_valid&&resp_ready, then resp_valid=0 and go to IDLE.
- Latency: resp_valid rises exactly LATENCY cycles after the acceptance edge. Back-to-back throughput is one request per LATENCY+2 cycles. req_ready is not asserted in the same cycle as the response handshake.
- Inputs are sampled only at acceptance. Changes while in BUSY or RESP are ignored.
- Packing per opcode (unused fields ignored):
  - R: funct7|rs2|rs1|f3|rd|op.
  - I/LOAD/JALR: imm[11:0]|rs1|f3|rd|op.
  - STORE: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - LUI/AUIPC: imm[31:12]|rd|op.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Unknown opcode: instruction=0, resp_err=1.
- All packing is pure bit selection; no arithmetic.

Optional Feature:
- Macro IENCODER_STRICT_EN.
- Defined: immediate range checks set resp_err=1 and still output the truncated packed word when:
  - I/LOAD/JALR/STORE: imm[31:11] not all equal.
  - BRANCH: imm[31:12] not all equal, or imm[0]=1.
  - JAL: imm[31:20] not all equal, or imm[0]=1.
  - LUI/AUIPC: imm[11:0]≠0.
  - R: funct7 not in {0x00,0x20}.
- Undefined: no range checks; bits are silently truncated; resp_err only for unknown opcode.

Decomposition:
- Package _riscv_defines:
  - Reuse opcode_t, REG_ADDR_WIDTH, DATA_WIDTH.
  - Add enc_state_t {ENC_IDLE, ENC_BUSY, ENC_RESP} and INSTR_NOP=32'h00000013 for benches.
- Sub-module iencoder_pack: purely combinational, latched fields → {instruction, err}. Holds the packing table and strict checks.
- iencoder holds FSM, counter and output registers.

Test Plan:
- addi: opcode=0x13, rd=1, rs1=0, f3=0, imm=5 → instruction=0x00500093, resp_err=0, resp_valid exactly 4 cycles after acceptance.
- add: opcode=0x33, rd=3, rs1=1, rs2=2, f7=0 → 0x002081B3. sw: opcode=0x23, rs1=1, rs2=2, f3=2, imm=8 → 0x0020A423.
- jal: opcode=0x6F, rd=0, imm=0xFFFFFFFC → 0xFFDFF06F. lui: opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7.
- Strict: opcode=0x13, imm=0x800 → resp_err=1 with IENCODER_STRICT_EN, 0 without. Opcode=0x7F → instruction=0, resp_err=1 in both builds.
- Backpressure: hold resp_ready=0 for 10 cycles in RESP → resp_valid and instruction stable, req_ready=0; release → one handshake, IDLE next cycle.
- Assert rst two cycles after acceptance → resp_valid=0 immediately. After release, a new request encodes correctly with full LATENCY; no stale response appears.

Source files
------------

// File: rtl/iencoder_pkg.sv
// Shared RV32I definitions for the instruction encoder: opcodes, FSM states,
// the latched request fields and the immediate range helper.
package iencoder_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'h03,
        OPC_OP_IMM = 7'h13,
        OPC_AUIPC  = 7'h17,
        OPC_STORE  = 7'h23,
        OPC_OP     = 7'h33,
        OPC_LUI    = 7'h37,
        OPC_BRANCH = 7'h63,
        OPC_JALR   = 7'h67,
        OPC_JAL    = 7'h6F
    } opcode_t;

    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_BUSY,
        ENC_RESP
    } enc_state_t;

    localparam logic [DATA_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

    // Opcode is kept as raw bits so unknown encodings survive to the packer.
    typedef struct packed {
        logic [6:0]                opcode;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [2:0]                funct3;
        logic [6:0]                funct7;
        logic [DATA_WIDTH-1:0]     imm;
    } enc_fields_t;

    // True when every bit selected by mask carries the same value.
    function automatic logic is_uniform(input logic [DATA_WIDTH-1:0] value,
                                        input logic [DATA_WIDTH-1:0] mask);
        return ((value & mask) == mask) || ((value & mask) == '0);
    endfunction

endpackage

// File: rtl/iencoder_pack.sv
// Combinational RV32I field packer: latched fields -> {instruction, err}.
// Immediate/funct7 range checks are compiled in with IENCODER_STRICT_EN.
module iencoder_pack
    import iencoder_pkg::*;
(
    input  enc_fields_t             fields,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic                    err
);

    logic [DATA_WIDTH-1:0] imm;
    assign imm = fields.imm;

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        instruction = '0;
        err         = 1'b0;
        case (fields.opcode)
            OPC_OP:
                instruction = {fields.funct7, fields.rs2, fields.rs1,
                               fields.funct3, fields.rd, fields.opcode};
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                instruction = {imm[11:0], fields.rs1, fields.funct3,
                               fields.rd, fields.opcode};
            OPC_STORE:
                instruction = {imm[11:5], fields.rs2, fields.rs1,
                               fields.funct3, imm[4:0], fields.opcode};
            OPC_BRANCH:
                instruction = {imm[12], imm[10:5], fields.rs2, fields.rs1,
                               fields.funct3, imm[4:1], imm[11], fields.opcode};
            OPC_LUI, OPC_AUIPC:
                instruction = {imm[31:12], fields.rd, fields.opcode};
            OPC_JAL:
                instruction = {imm[20], imm[10:1], imm[11], imm[19:12],
                               fields.rd, fields.opcode};
            default:
                err = 1'b1;
        endcase

`ifdef IENCODER_STRICT_EN
        // Out-of-range values still emit the truncated word, only flagged.
        case (fields.opcode)
            OPC_OP:
                if (fields.funct7 != 7'h00 && fields.funct7 != 7'h20) err = 1'b1;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE:
                if (!is_uniform(imm, 32'hFFFF_F800)) err = 1'b1;
            OPC_BRANCH:
                if (!is_uniform(imm, 32'hFFFF_F000) || imm[0]) err = 1'b1;
            OPC_JAL:
                if (!is_uniform(imm, 32'hFFF0_0000) || imm[0]) err = 1'b1;
            OPC_LUI, OPC_AUIPC:
                if (imm[11:0] != 12'h000) err = 1'b1;
            default: ;
        endcase
`endif
    end

endmodule

// File: rtl/iencoder.sv
// RV32I instruction encoder with valid/ready handshakes and a fixed LATENCY
// delay model. Optional strict immediate checks: define IENCODER_STRICT_EN.
module iencoder #(
    parameter int LATENCY        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [6:0]                opcode,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic [2:0]                funct3,
    input  logic [6:0]                funct7,
    input  logic [DATA_WIDTH-1:0]     imm,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     instruction,
    output logic                      resp_err
);

    import iencoder_pkg::*;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    enc_state_t            state_q, state_d;
    logic [3:0]            count_q, count_d;
    enc_fields_t           fields_q, fields_d;
    enc_fields_t           req_fields;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  err_q, err_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] pack_instr;
    logic                  pack_err;

    always_comb begin
        req_fields.opcode = opcode;
        req_fields.rd     = rd_addr;
        req_fields.rs1    = rs1_addr;
        req_fields.rs2    = rs2_addr;
        req_fields.funct3 = funct3;
        req_fields.funct7 = funct7;
        req_fields.imm    = imm;
    end

    iencoder_pack u_pack (
        .fields      (fields_q),
        .instruction (pack_instr),
        .err         (pack_err)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        fields_d = fields_q;
        instr_d  = instr_q;
        err_d    = err_q;
        valid_d  = valid_q;
        case (state_q)
            ENC_IDLE: begin
                if (req_valid) begin
                    fields_d = req_fields;
                    count_d  = CNT_LOAD;
                    state_d  = ENC_BUSY;
                end
            end
            ENC_BUSY: begin
                if (count_q == 4'd0) begin
                    instr_d = pack_instr;
                    err_d   = pack_err;
                    valid_d = 1'b1;
                    state_d = ENC_RESP;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            ENC_RESP: begin
                if (resp_ready) begin
                    valid_d = 1'b0;
                    state_d = ENC_IDLE;
                end
            end
            default: state_d = ENC_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block ordering.
    // NOTE: the latched fields are reset too; they are a handful of flops, not
    // a memory, and resetting them keeps the packer output deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ENC_IDLE;
            count_q  <= '0;
            fields_q <= '0;
            instr_q  <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            fields_q <= fields_d;
            instr_q  <= instr_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign req_ready   = (state_q == ENC_IDLE) && !rst;
    assign resp_valid  = valid_q;
    assign instruction = instr_q;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_iencoder.sv
// Directed self-checking bench for iencoder: packing formats, latency,
// backpressure, back-to-back throughput and mid-operation reset.
`timescale 1ns/1ps
module tb_iencoder;

    import iencoder_pkg::*;

    localparam int LAT = 4;
`ifdef IENCODER_STRICT_EN
    localparam logic STRICT = 1'b1;
`else
    localparam logic STRICT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] instruction;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iencoder #(.LATENCY(LAT), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .opcode      (opcode),
        .rd_addr     (rd_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .funct3      (funct3),
        .funct7      (funct7),
        .imm         (imm),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .instruction (instruction),
        .resp_err    (resp_err)
    );

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] im);
        opcode = op; rd_addr = rd; rs1_addr = rs1; rs2_addr = rs2;
        funct3 = f3; funct7 = f7; imm = im;
    endtask

    // Full transaction: accept, measure latency, check word, complete handshake.
    task automatic run_op(input string name, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] im,
                          input logic [31:0] exp_instr, input logic exp_err);
        int lat;
        bit got;
        bit ready_leak;
        @(negedge clk);
        drive(op, rd, rs1, rs2, f3, f7, im);
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drive(7'h55, 5'h1F, 5'h1F, 5'h1F, 3'h7, 7'h7F, 32'hDEAD_BEEF);
        lat = 0;
        got = 1'b0;
        ready_leak = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (resp_valid === 1'b1) got = 1'b1;
            else if (req_ready !== 1'b0) ready_leak = 1'b1;
        end
        checks++;
        if (!got || lat != LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (seen=%0b) want %0d", name, lat, got, LAT);
        end
        checks++;
        if (ready_leak) begin
            errors++;
            $display("FAIL %s req_ready while busy: got 1 want 0", name);
        end
        checks++;
        if (instruction !== exp_instr) begin
            errors++;
            $display("FAIL %s instruction: got %08h want %08h", name, instruction, exp_instr);
        end
        checks++;
        if (resp_err !== exp_err) begin
            errors++;
            $display("FAIL %s resp_err: got %b want %b", name, resp_err, exp_err);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after handshake: resp_valid=%b req_ready=%b want 0/1",
                     name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        drive(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || instruction !== 32'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: req_ready=%b resp_valid=%b instr=%08h err=%b want 0/0/0/0",
                     req_ready, resp_valid, instruction, resp_err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset release req_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_formats();
        run_op("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h0050_0093, 1'b0);
        run_op("add",  7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h0020_81B3, 1'b0);
        run_op("sw",   7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020_A423, 1'b0);
        run_op("beq",  7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0);
        run_op("jal",  7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0);
        run_op("lui",  7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        run_op("nop",  7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        INSTR_NOP,     1'b0);
    endtask

    task automatic test_errors();
        run_op("imm_range", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0093, STRICT);
        run_op("unknown_op", 7'h7F, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0123, 32'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        int waited;
        bit stable_ok;
        resp_ready = 1'b0;
        @(negedge clk);
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drive(7'h33, 5'd9, 5'd9, 5'd9, 3'd1, 7'h20, 32'hFFFF_FFFF);
        waited = 0;
        while (resp_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure response: resp_valid=%b after %0d cycles want 1", resp_valid, waited);
        end
        stable_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || instruction !== 32'h0050_0093 || req_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        checks++;
        if (!stable_ok) begin
            errors++;
            $display("FAIL backpressure hold: resp_valid=%b instr=%08h req_ready=%b want 1/00500093/0",
                     resp_valid, instruction, req_ready);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure release: resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int first_idx;
        int second_idx;
        bit overlap;
        first_idx = -1;
        second_idx = -1;
        overlap = 1'b0;
        @(negedge clk);
        drive(7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (req_ready === 1'b1) begin
                if (first_idx < 0) first_idx = i;
                else if (second_idx < 0) second_idx = i;
            end
            if (req_ready === 1'b1 && resp_valid === 1'b1) overlap = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (first_idx != 0 || second_idx != LAT + 2) begin
            errors++;
            $display("FAIL back_to_back spacing: accepts at %0d,%0d want 0,%0d", first_idx, second_idx, LAT + 2);
        end
        checks++;
        if (overlap) begin
            errors++;
            $display("FAIL back_to_back req_ready during response: got 1 want 0");
        end
        // Drain the second request accepted inside the window.
        repeat (20) begin
            if (req_ready !== 1'b1) @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        bit stale;
        @(negedge clk);
        drive(7'h33, 5'd7, 5'd4, 5'd5, 3'd0, 7'd0, 32'd0);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset outputs: resp_valid=%b req_ready=%b want 0/0", resp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL mid_reset stale response: resp_valid seen 1 want 0");
        end
        run_op("post_reset_addi", 7'h13, 5'd10, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,
               32'hFFF1_0513, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_formats();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
